// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared funct3 codes, fault causes and FSM state type for data_mem_sized
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE    = 2'd2;
  localparam logic [1:0] CAUSE_FUNCT3   = 2'd3;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

endpackage

// File: rtl/data_mem_lane_align.sv
// rtl/data_mem_lane_align.sv - store lane enables/replication and load lane select/extension
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data_in,
  output logic [3:0]  byte_en,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    byte_en = 4'b0000;
    st_data = st_data_in;
    case (st_size)
      2'b00: begin
        byte_en = 4'b0001 << st_offset;
        st_data = {4{st_data_in[7:0]}};
      end
      2'b01: begin
        byte_en = st_offset[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_data_in[15:0]}};
      end
      2'b10: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[8*ld_offset +: 8];
    ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = '0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// rtl/data_mem_sized.sv - sized RV32I data memory with fault checks, registered read and clear sequencer
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        resp_fault,
  output logic [1:0]  resp_cause,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          funct3_ok, in_range, misaligned;
  logic [1:0]    cause;
  logic [AW-1:0] idx;
  logic [3:0]    byte_en;
  logic [31:0]   st_data;

  logic [31:0]   raw_q;
  logic [2:0]    ld_funct3_q;
  logic [1:0]    ld_offset_q;
  logic          ld_ok_q;
  logic [31:0]   ld_data;

  assign busy      = (state == ST_CLEAR);
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready;
  assign idx       = address[AW+1:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + AW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_CLEAR && clr_cnt == AW'(DEPTH_WORDS - 1)) state_next = ST_IDLE;
  end

  // Loads accept the unsigned variants; stores only B/H/W.
  always_comb begin
    if (req_write)
      funct3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      funct3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                  (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    in_range   = (address[31:AW+2] == '0);
    misaligned = ((req_funct3[1:0] == 2'b01) && address[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    cause = CAUSE_NONE;
    if (!funct3_ok)     cause = CAUSE_FUNCT3;
    else if (!in_range) cause = CAUSE_RANGE;
    else if (misaligned) cause = CAUSE_MISALIGN;
  end

  data_mem_lane_align u_lane_align (
    .st_size    (req_funct3[1:0]),
    .st_offset  (address[1:0]),
    .st_data_in (write_data),
    .byte_en    (byte_en),
    .st_data    (st_data),
    .ld_funct3  (ld_funct3_q),
    .ld_offset  (ld_offset_q),
    .ld_word    (raw_q),
    .ld_data    (ld_data)
  );

  // Storage carries no reset; the clear sequencer owns its initial contents.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_write && cause == CAUSE_NONE) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
    end
    if (accept) raw_q <= mem[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_fault  <= 1'b0;
      resp_cause  <= CAUSE_NONE;
      ld_ok_q     <= 1'b0;
      ld_funct3_q <= '0;
      ld_offset_q <= '0;
    end else begin
      resp_valid  <= accept;
      resp_fault  <= accept && (cause != CAUSE_NONE);
      resp_cause  <= accept ? cause : CAUSE_NONE;
      ld_ok_q     <= accept && !req_write && (cause == CAUSE_NONE);
      ld_funct3_q <= req_funct3;
      ld_offset_q <= address[1:0];
    end
  end

  assign read_data = ld_ok_q ? ld_data : '0;

endmodule

// File: tb/tb_data_mem_sized.sv
// tb/tb_data_mem_sized.sv - randomized self-checking bench for data_mem_sized against a byte-array model
module tb_data_mem_sized;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_mem [128];

  data_mem_sized #(.DEPTH_WORDS(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .address(address),
    .write_data(write_data), .resp_valid(resp_valid), .read_data(read_data),
    .resp_fault(resp_fault), .resp_cause(resp_cause), .busy(busy)
  );

  always #5 clock = ~clock;

  // Byte-addressed reference: computes the expected cause/data and applies legal stores.
  task automatic model_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [1:0] cause, output logic [31:0] data);
    int size;
    logic legal;
    logic [31:0] v;
    size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    data  = 32'd0;
    if (!legal) cause = 2'd3;
    else if (a >= 32'd128) cause = 2'd2;
    else if (a % size != 0) cause = 2'd1;
    else cause = 2'd0;
    if (cause == 2'd0) begin
      if (w) begin
        for (int k = 0; k < size; k++) model_mem[a + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < size; k++) v = v | (32'(model_mem[a + k]) << (8 * k));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        data = v;
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic rv, output logic [31:0] rd, output logic rf, output logic [1:0] rc);
    int n;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; address = a; write_data = wd;
    n = 0;
    while (!req_ready && n < 200) begin @(posedge clock); #1; n++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL req_ready_timeout got=0 want=1");
    end
    @(posedge clock); #1;
    rv = resp_valid; rd = read_data; rf = resp_fault; rc = resp_cause;
    req_valid = 1'b0;
  endtask

  task automatic apply_reset_and_clear(output int n);
    reset = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(posedge clock); #1; n++; end
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({resp_valid, resp_fault, resp_cause} !== 4'b0 || read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b/%h want=0000/00000000", {resp_valid, resp_fault, resp_cause}, read_data);
    end
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_busy got busy=%b ready=%b want busy=1 ready=0", busy, req_ready);
    end
    apply_reset_and_clear(n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL clear_cycles got=%0d want=32", n); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clear got=%b want=1", req_ready); end
  endtask

  task automatic test_clear_contents;
    logic rv, rf; logic [31:0] rd; logic [1:0] rc;
    logic [31:0] addrs [2];
    addrs[0] = 32'h00; addrs[1] = 32'h7C;
    for (int i = 0; i < 2; i++) begin
      do_req(1'b0, 3'd2, addrs[i], 32'd0, rv, rd, rf, rc);
      checks++;
      if (rv !== 1'b1 || rd !== 32'd0 || rf !== 1'b0) begin
        errors++; $display("FAIL clear_lw@%h got v=%b d=%h f=%b want v=1 d=0 f=0", addrs[i], rv, rd, rf);
      end
    end
  endtask

  task automatic test_widths;
    logic rv, rf; logic [31:0] rd; logic [1:0] rc, mc; logic [31:0] md;
    logic [2:0]  f3s [5];
    logic [31:0] ads [5];
    logic [31:0] exp [5];
    f3s[0] = 3'd0; ads[0] = 32'h10; exp[0] = 32'hFFFF_FFF3;
    f3s[1] = 3'd4; ads[1] = 32'h11; exp[1] = 32'h0000_0082;
    f3s[2] = 3'd1; ads[2] = 32'h12; exp[2] = 32'hFFFF_8081;
    f3s[3] = 3'd5; ads[3] = 32'h10; exp[3] = 32'h0000_82F3;
    f3s[4] = 3'd2; ads[4] = 32'h10; exp[4] = 32'h8081_82F3;
    do_req(1'b1, 3'd2, 32'h10, 32'h8081_82F3, rv, rd, rf, rc);
    model_req(1'b1, 3'd2, 32'h10, 32'h8081_82F3, mc, md);
    checks++;
    if (rv !== 1'b1 || rd !== 32'd0 || rf !== 1'b0) begin
      errors++; $display("FAIL sw_resp got v=%b d=%h f=%b want v=1 d=0 f=0", rv, rd, rf);
    end
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], ads[i], 32'd0, rv, rd, rf, rc);
      model_req(1'b0, f3s[i], ads[i], 32'd0, mc, md);
      checks++;
      if (rd !== exp[i] || rf !== 1'b0 || rv !== 1'b1) begin
        errors++; $display("FAIL load_f3=%0d@%h got=%h want=%h", f3s[i], ads[i], rd, exp[i]);
      end
    end
  endtask

  task automatic test_merge;
    logic rv, rf; logic [31:0] rd; logic [1:0] rc, mc; logic [31:0] md;
    do_req(1'b1, 3'd2, 32'h20, 32'hAAAA_AAAA, rv, rd, rf, rc); model_req(1'b1, 3'd2, 32'h20, 32'hAAAA_AAAA, mc, md);
    do_req(1'b1, 3'd0, 32'h22, 32'h0000_0055, rv, rd, rf, rc); model_req(1'b1, 3'd0, 32'h22, 32'h0000_0055, mc, md);
    do_req(1'b1, 3'd1, 32'h20, 32'h0000_1234, rv, rd, rf, rc); model_req(1'b1, 3'd1, 32'h20, 32'h0000_1234, mc, md);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, rv, rd, rf, rc);
    checks++;
    if (rd !== 32'hAA55_1234) begin errors++; $display("FAIL merge_lw@20 got=%h want=aa551234", rd); end
    for (int a = 32'h1C; a <= 32'h24; a += 8) begin
      do_req(1'b0, 3'd2, 32'(a), 32'd0, rv, rd, rf, rc);
      model_req(1'b0, 3'd2, 32'(a), 32'd0, mc, md);
      checks++;
      if (rd !== md) begin errors++; $display("FAIL merge_neighbour@%h got=%h want=%h", a, rd, md); end
    end
  endtask

  task automatic test_faults;
    logic rv, rf; logic [31:0] rd; logic [1:0] rc;
    logic        ws [6];
    logic [2:0]  fs [6];
    logic [31:0] as [6];
    logic [1:0]  cs [6];
    ws[0] = 1'b0; fs[0] = 3'd2; as[0] = 32'h02; cs[0] = 2'd1;
    ws[1] = 1'b1; fs[1] = 3'd1; as[1] = 32'h81; cs[1] = 2'd2;
    ws[2] = 1'b0; fs[2] = 3'd3; as[2] = 32'h10; cs[2] = 2'd3;
    ws[3] = 1'b1; fs[3] = 3'd2; as[3] = 32'h12; cs[3] = 2'd1;
    ws[4] = 1'b1; fs[4] = 3'd4; as[4] = 32'h10; cs[4] = 2'd3;
    ws[5] = 1'b1; fs[5] = 3'd2; as[5] = 32'h8000_0010; cs[5] = 2'd2;
    for (int i = 0; i < 6; i++) begin
      do_req(ws[i], fs[i], as[i], 32'hDEAD_BEEF, rv, rd, rf, rc);
      checks++;
      if (rv !== 1'b1 || rf !== 1'b1 || rc !== cs[i] || rd !== 32'd0) begin
        errors++; $display("FAIL fault_%0d got v=%b f=%b c=%0d d=%h want v=1 f=1 c=%0d d=0", i, rv, rf, rc, rd, cs[i]);
      end
    end
    do_req(1'b0, 3'd2, 32'h10, 32'd0, rv, rd, rf, rc);
    checks++;
    if (rd !== 32'h8081_82F3) begin errors++; $display("FAIL fault_no_write got=%h want=808182f3", rd); end
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 1'b0 || read_data !== 32'd0 || resp_fault !== 1'b0 || resp_cause !== 2'd0) begin
      errors++; $display("FAIL idle_outputs got v=%b d=%h f=%b c=%0d want all 0", resp_valid, read_data, resp_fault, resp_cause);
    end
  endtask

  task automatic test_random;
    logic rv, rf; logic [31:0] rd; logic [1:0] rc, mc; logic [31:0] md;
    logic w; logic [2:0] f3; logic [31:0] a, wd;
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 135));
      wd = $urandom;
      do_req(w, f3, a, wd, rv, rd, rf, rc);
      model_req(w, f3, a, wd, mc, md);
      checks++;
      if (rv !== 1'b1 || rc !== mc || rf !== (mc != 2'd0) || rd !== md) begin
        errors++;
        $display("FAIL rand_%0d w=%b f3=%0d a=%h got v=%b c=%0d f=%b d=%h want v=1 c=%0d d=%h",
                 i, w, f3, a, rv, rc, rf, rd, mc, md);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [1:0] mc [4]; logic [31:0] md [4];
    logic        ws [4]; logic [2:0] fs [4]; logic [31:0] as [4]; logic [31:0] ds [4];
    ws[0] = 1'b1; fs[0] = 3'd2; as[0] = 32'h40; ds[0] = 32'h1122_3344;
    ws[1] = 1'b0; fs[1] = 3'd2; as[1] = 32'h40; ds[1] = 32'd0;
    ws[2] = 1'b0; fs[2] = 3'd0; as[2] = 32'h41; ds[2] = 32'd0;
    ws[3] = 1'b1; fs[3] = 3'd1; as[3] = 32'h43; ds[3] = 32'hFFFF;
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(posedge clock); #1; n++; end
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
    checks++;
    if (n != 32) begin errors++; $display("FAIL midclear_restart got=%0d want=32", n); end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = ws[i]; req_funct3 = fs[i]; address = as[i]; write_data = ds[i];
      model_req(ws[i], fs[i], as[i], ds[i], mc[i], md[i]);
      @(posedge clock); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_cause !== mc[i] || read_data !== md[i]) begin
        errors++; $display("FAIL b2b_%0d got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                           i, resp_valid, resp_cause, read_data, mc[i], md[i]);
      end
    end
    req_valid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got v=%b want v=0", resp_valid); end
  endtask

  initial begin
    test_reset;
    test_clear_contents;
    test_widths;
    test_merge;
    test_faults;
    test_random;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_sized.md
# data_mem_sized

Parametrised data memory for the RISC-V core's MEM stage, successor to the fixed 128-byte word-only memory. Supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) via funct3, with per-byte write enables and sign/zero extension. Uses a registered read with a valid/ready request handshake and reports misaligned, out-of-range and illegal-funct3 faults. A post-reset clear sequencer zeroes the array, so no reset fan-out into storage is needed.

## Interface
- DEPTH_WORDS, 32: number of 32-bit words; power of two, at least 4.
- CLEAR_ON_RESET, 1: 1 runs the zeroing sequencer after reset; 0 goes directly to IDLE with contents undefined.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- address  in  32  byte address.
- write_data  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  single-cycle pulse, one per accepted request.
- read_data  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  request faulted; memory untouched.
- resp_cause  out  2  0 none, 1 misaligned, 2 out-of-range, 3 illegal funct3.
- busy  out  1  clear sequencer active.

## Operation
- FSM states:
  - CLEAR: writes zero to word clr_cnt, increments clr_cnt each cycle; after word DEPTH_WORDS-1 goes to IDLE.
  - IDLE: req_ready = 1.
- busy = (state == CLEAR); req_ready = !busy.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes → cause 3.
- Range: address ≥ 4·DEPTH_WORDS → cause 2. No wrap-around.
- Alignment: halfword with address[0]=1, or word with address[1:0]≠0 → cause 1.
- Fault priority: illegal funct3 > range > misaligned. A faulting request does not write memory, and returns resp_fault=1 with read_data=0.
- Stores:
  - Byte enables: SB → 1 lane at address[1:0]; SH → 2 lanes at address[1]; SW → all 4 lanes.
  - Data is replicated across lanes, and only enabled lanes update.
- Loads: read the word at address[log2(DEPTH_WORDS)+1:2]; select the lane and extend per funct3 (LB/LH sign-extend, LBU/LHU zero-extend).

## Timing
- Reset asserted: state=CLEAR (IDLE if CLEAR_ON_RESET=0), clr_cnt=0, resp_valid=0, read_data=0, resp_fault=0, resp_cause=0. busy=1, req_ready=0 while in CLEAR.
- Clear phase:
  - Takes DEPTH_WORDS cycles; req_ready rises on the edge after the last clear write.
  - Reset asserted mid-clear restarts the clear from word 0.
- Accepted request at edge N: resp_valid=1 with read_data, resp_fault and resp_cause valid during cycle N+1. Latency is 1 for both loads and stores.
- Throughput: back-to-back requests are accepted every cycle, and a response pulse follows each.
- Store commits at the acceptance edge. A load accepted on the next edge returns the new data; there is no forwarding hazard.
- With no acceptance, resp_valid=0 and read_data, resp_fault and resp_cause return to 0.
- req_valid during CLEAR is not accepted. The requester holds the request until req_ready is high.

## Structure
- Package data_mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Cause codes CAUSE_NONE, CAUSE_MISALIGN, CAUSE_RANGE, CAUSE_FUNCT3.
  - State enum {ST_CLEAR, ST_IDLE}.
- Sub-module data_mem_lane_align (combinational) handles:
  - funct3 plus address[1:0] → byte enables and replicated store data.
  - Raw word plus stored funct3/offset → extended load data.
- The top level holds the FSM, fault checks, word array and response registers.
- Load funct3 and offset are registered alongside the read.

## Test plan
- Reset, then idle with DEPTH_WORDS=32 → busy for exactly 32 cycles; req_ready rises on cycle 32; LW of addresses 0x00 and 0x7C both return 0.
- SW 0x8081_82F3 @0x10, then LB/LBU/LH/LHU/LW @0x10–0x13 → LB@0x10 = 0xFFFF_FFF3; LBU@0x11 = 0x0000_0082; LH@0x12 = 0xFFFF_8081; LHU@0x10 = 0x0000_82F3; LW = 0x8081_82F3.
- SW 0xAAAA_AAAA @0x20, then SB 0x55 @0x22, then SH 0x1234 @0x20 → LW@0x20 = 0xAA55_1234; other words unchanged.
- Faults:
  - LW@0x02 → cause 1.
  - SH@0x81 → cause 2 (range beats misaligned).
  - funct3 011 load → cause 3.
  - Each faulting store leaves memory unchanged (checked by a subsequent LW).
- Assert reset at clear cycle 10, release, then issue back-to-back requests → clear restarts (32 more busy cycles); then 4 consecutive requests give 4 consecutive resp_valid pulses with no gaps.
